// File: rtl/panel_key_ctr.sv
// Front-panel switch conditioner: 2-FF synchroniser, debounce filter and a
// press-classification FSM producing press/short/long pulses and a toggled sig_mode.
module panel_key_ctr #(
  parameter logic [19:0] DEBOUNCE_CNT   = 20'd400000,
  parameter logic [25:0] LONG_PRESS_CNT = 26'd40000000,
  parameter logic        SW_ACTIVE_LOW  = 1'b1,
  parameter logic        SIG_MODE_INIT  = 1'b0
) (
  input  logic       clk_20mhz,
  input  logic       rst_n,
  input  logic       panel_sw,
  output logic       sw_level,
  output logic       sw_press_pulse,
  output logic       sw_short_pulse,
  output logic       sw_long_pulse,
  output logic       sig_mode,
  output logic [1:0] key_state
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_PRESSED = 2'b01;
  localparam logic [1:0] ST_LONG    = 2'b10;

  // Handshake-free block: every output is a registered level or a 1-cycle pulse.

  logic        sw_raw;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        sw_level_q, sw_level_d;
  logic [1:0]  state_q, state_d;
  logic [25:0] hold_cnt_q, hold_cnt_d;
  logic        press_q, press_d;
  logic        short_q, short_d;
  logic        long_q, long_d;
  logic        sig_mode_q, sig_mode_d;
  logic        hold_at_thr;

  // Normalise polarity before synchronising so the sync FFs reset to "released".
  assign sw_raw = SW_ACTIVE_LOW ? ~panel_sw : panel_sw;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
  end

  always_comb begin
    db_cnt_d   = db_cnt_q;
    sw_level_d = sw_level_q;
    if (sync2_q == sw_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DEBOUNCE_CNT - 20'd1) begin
      sw_level_d = sync2_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      sw_level_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      sw_level_q <= sw_level_d;
    end
  end

  assign hold_at_thr = (hold_cnt_q == LONG_PRESS_CNT - 26'd1);

  // FSM state register, together with its registered outputs.
  always_ff @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      sig_mode_q <= SIG_MODE_INIT;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      short_q    <= short_d;
      long_q     <= long_d;
      sig_mode_q <= sig_mode_d;
    end
  end

  // Next-state: release is tested before the threshold so it wins on a tie.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sw_level_q) begin
          state_d    = ST_PRESSED;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        if (!sw_level_q) begin
          state_d = ST_IDLE;
        end else if (hold_at_thr) begin
          state_d = ST_LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 26'd1;
        end
      end
      ST_LONG: begin
        if (!sw_level_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: pulses are registered so they line up with the state change.
  always_comb begin
    press_d    = (state_q == ST_IDLE) && sw_level_q;
    short_d    = (state_q == ST_PRESSED) && !sw_level_q;
    long_d     = (state_q == ST_PRESSED) && sw_level_q && hold_at_thr;
    sig_mode_d = sig_mode_q ^ short_d;
  end

  assign sw_level       = sw_level_q;
  assign sw_press_pulse = press_q;
  assign sw_short_pulse = short_q;
  assign sw_long_pulse  = long_q;
  assign sig_mode       = sig_mode_q;
  assign key_state      = state_q;

endmodule

// File: tb/tb_panel_key_ctr.sv
// Self-checking bench for panel_key_ctr: per-cycle comparison against a
// timestamp-based reference model plus scenario-specific checks.
`timescale 1ns/1ps
module tb_panel_key_ctr;

  localparam int DEB  = 8;
  localparam int LONG = 50;

  logic       clk_20mhz = 1'b0;
  logic       rst_n     = 1'b1;
  logic       panel_sw  = 1'b1;
  logic       sw_level;
  logic       sw_press_pulse;
  logic       sw_short_pulse;
  logic       sw_long_pulse;
  logic       sig_mode;
  logic [1:0] key_state;

  int n_cmp = 0;
  int n_err = 0;

  panel_key_ctr #(
    .DEBOUNCE_CNT  (20'd8),
    .LONG_PRESS_CNT(26'd50),
    .SW_ACTIVE_LOW (1'b1),
    .SIG_MODE_INIT (1'b0)
  ) dut (
    .clk_20mhz     (clk_20mhz),
    .rst_n         (rst_n),
    .panel_sw      (panel_sw),
    .sw_level      (sw_level),
    .sw_press_pulse(sw_press_pulse),
    .sw_short_pulse(sw_short_pulse),
    .sw_long_pulse (sw_long_pulse),
    .sig_mode      (sig_mode),
    .key_state     (key_state)
  );

  // clock / reset
  always #25 clk_20mhz = ~clk_20mhz;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running, required finished");
    $fatal(1, "timeout");
  end

  // Reference model: pin delayed two cycles, accepted after DEB consecutive
  // disagreeing cycles; presses classified by elapsed time since the press event.
  logic m_d1, m_d2, m_lvl;
  int   m_run;
  logic m_in, m_long;
  int   m_t, m_cyc;
  logic m_press, m_short, m_lp, m_mode;

  always @(posedge clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_lvl <= 1'b0; m_run <= 0;
      m_in <= 1'b0; m_long <= 1'b0; m_t <= 0; m_cyc <= 0;
      m_press <= 1'b0; m_short <= 1'b0; m_lp <= 1'b0; m_mode <= 1'b0;
    end else begin
      m_press <= 1'b0;
      m_short <= 1'b0;
      m_lp    <= 1'b0;
      if (!m_in) begin
        if (m_lvl) begin
          m_in <= 1'b1; m_long <= 1'b0; m_t <= m_cyc; m_press <= 1'b1;
        end
      end else if (!m_lvl) begin
        m_in <= 1'b0;
        if (!m_long) begin
          m_short <= 1'b1;
          m_mode  <= ~m_mode;
        end
      end else if (!m_long && (m_cyc - m_t == LONG)) begin
        m_lp <= 1'b1; m_long <= 1'b1;
      end
      if (m_d2 != m_lvl) begin
        if (m_run + 1 == DEB) begin
          m_lvl <= m_d2;
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      m_d2  <= m_d1;
      m_d1  <= ~panel_sw;
      m_cyc <= m_cyc + 1;
    end
  end

  logic [6:0] dut_vec, exp_vec;
  assign dut_vec = {sw_level, sw_press_pulse, sw_short_pulse, sw_long_pulse, sig_mode, key_state};
  assign exp_vec = {m_lvl, m_press, m_short, m_lp, m_mode, m_in ? (m_long ? 2'd2 : 2'd1) : 2'd0};

  task automatic test_reset;
    panel_sw = 1'b1;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk_20mhz);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_20mhz);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL reset cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    n_cmp++;
    if (dut_vec !== 7'b0) begin
      n_err++;
      $display("FAIL reset_idle: got %b expected 0000000", dut_vec);
    end
  endtask

  task automatic test_short_press;
    for (int p = 0; p < 2; p++) begin
      bit pat[$];
      int rise_at, n_press, n_short, n_long;
      rise_at = -1; n_press = 0; n_short = 0; n_long = 0;
      repeat (5)  pat.push_back(1'b1);
      repeat (20) pat.push_back(1'b0);
      repeat (20) pat.push_back(1'b1);
      for (int i = 0; i < pat.size(); i++) begin
        panel_sw = pat[i];
        @(negedge clk_20mhz);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++;
          $display("FAIL short_press p%0d cyc %0d: got %b expected %b", p, i, dut_vec, exp_vec);
        end
        if (sw_level && rise_at < 0) rise_at = i - 4;
        if (sw_press_pulse) n_press++;
        if (sw_short_pulse) n_short++;
        if (sw_long_pulse)  n_long++;
      end
      n_cmp++;
      if (rise_at < 10 || rise_at > 11) begin
        n_err++;
        $display("FAIL short_latency p%0d: got %0d expected 10..11", p, rise_at);
      end
      n_cmp++;
      if (n_press != 1 || n_short != 1 || n_long != 0) begin
        n_err++;
        $display("FAIL short_pulses p%0d: got press=%0d short=%0d long=%0d expected 1/1/0",
                 p, n_press, n_short, n_long);
      end
      n_cmp++;
      if (sig_mode !== (p == 0)) begin
        n_err++;
        $display("FAIL short_mode p%0d: got %b expected %b", p, sig_mode, (p == 0));
      end
    end
  endtask

  task automatic test_glitch;
    bit pat[$];
    int n_evt;
    n_evt = 0;
    repeat (5) pat.push_back(1'b0);
    for (int i = 0; i < 40; i++) pat.push_back(((i / 3) % 2) == 0);
    repeat (20) pat.push_back(1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      panel_sw = pat[i];
      @(negedge clk_20mhz);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL glitch cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      if (sw_level || sw_press_pulse || sw_short_pulse || sw_long_pulse) n_evt++;
    end
    n_cmp++;
    if (n_evt != 0) begin
      n_err++;
      $display("FAIL glitch_quiet: got %0d active cycles expected 0", n_evt);
    end
  endtask

  task automatic test_long_press;
    bit pat[$];
    int t_press, t_long, n_short;
    logic [1:0] ks_long;
    logic mode_before;
    t_press = -1; t_long = -1; n_short = 0; ks_long = 2'b11;
    mode_before = m_mode;
    repeat (200) pat.push_back(1'b0);
    repeat (30)  pat.push_back(1'b1);
    for (int i = 0; i < pat.size(); i++) begin
      panel_sw = pat[i];
      @(negedge clk_20mhz);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL long_press cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      if (sw_press_pulse) t_press = i;
      if (sw_long_pulse) begin t_long = i; ks_long = key_state; end
      if (sw_short_pulse) n_short++;
    end
    n_cmp++;
    if (t_press < 0 || t_long - t_press != LONG) begin
      n_err++;
      $display("FAIL long_delay: got %0d expected %0d", t_long - t_press, LONG);
    end
    n_cmp++;
    if (ks_long !== 2'b10) begin
      n_err++;
      $display("FAIL long_state: got %b expected 10", ks_long);
    end
    n_cmp++;
    if (n_short != 0 || sig_mode !== mode_before) begin
      n_err++;
      $display("FAIL long_release: got short=%0d mode=%b expected 0/%b", n_short, sig_mode, mode_before);
    end
  endtask

  // Pin low 50 cycles: release lands on the threshold cycle (short wins);
  // 51 cycles: one cycle later, so the long pulse fires instead.
  task automatic test_release_boundary;
    for (int c = 0; c < 2; c++) begin
      bit pat[$];
      int t_press, t_evt, n_short, n_long;
      logic mode_exp;
      t_press = -1; t_evt = -1; n_short = 0; n_long = 0;
      mode_exp = (c == 0) ? ~m_mode : m_mode;
      repeat (LONG + c) pat.push_back(1'b0);
      repeat (30)       pat.push_back(1'b1);
      for (int i = 0; i < pat.size(); i++) begin
        panel_sw = pat[i];
        @(negedge clk_20mhz);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++;
          $display("FAIL boundary c%0d cyc %0d: got %b expected %b", c, i, dut_vec, exp_vec);
        end
        if (sw_press_pulse) t_press = i;
        if (sw_short_pulse) begin n_short++; t_evt = i; end
        if (sw_long_pulse)  begin n_long++;  t_evt = i; end
      end
      n_cmp++;
      if (n_short != (c == 0) || n_long != (c == 1)) begin
        n_err++;
        $display("FAIL boundary_kind c%0d: got short=%0d long=%0d expected %0d/%0d",
                 c, n_short, n_long, (c == 0), (c == 1));
      end
      n_cmp++;
      if (t_press < 0 || t_evt - t_press != LONG) begin
        n_err++;
        $display("FAIL boundary_delay c%0d: got %0d expected %0d", c, t_evt - t_press, LONG);
      end
      n_cmp++;
      if (sig_mode !== mode_exp) begin
        n_err++;
        $display("FAIL boundary_mode c%0d: got %b expected %b", c, sig_mode, mode_exp);
      end
    end
  endtask

  task automatic test_reset_mid_press;
    int waited, t_press, n_bad;
    waited = 0; t_press = -1; n_bad = 0;
    panel_sw = 1'b0;
    while (key_state !== 2'b01 && waited < 30) begin
      @(negedge clk_20mhz);
      waited++;
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL midrst_pre cyc %0d: got %b expected %b", waited, dut_vec, exp_vec);
      end
    end
    n_cmp++;
    if (key_state !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_reach: got key_state %b expected 01", key_state);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_20mhz);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL midrst_hold cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_20mhz);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL midrst_post cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
      if (sw_press_pulse && t_press < 0) t_press = i;
      if (sw_short_pulse || sw_long_pulse) n_bad++;
    end
    n_cmp++;
    if (t_press < 10 || t_press > 11) begin
      n_err++;
      $display("FAIL midrst_repress: got %0d cycles expected 10..11", t_press);
    end
    n_cmp++;
    if (n_bad != 0 || sig_mode !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clean: got bad=%0d mode=%b expected 0/0", n_bad, sig_mode);
    end
    panel_sw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_20mhz);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL midrst_release cyc %0d: got %b expected %b", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 40; s++) begin
      logic v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 70));
      for (int i = 0; i < len; i++) begin
        panel_sw = v;
        @(negedge clk_20mhz);
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_err++;
          $display("FAIL random seg %0d cyc %0d: got %b expected %b", s, i, dut_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_glitch();
    test_long_press();
    test_release_boundary();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
